// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory and (with MEM_ARB_STATS_EN) stall-counter signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_bus_arbiter_if;
  logic        r0_req;
  logic        r0_lock;
  logic        r0_we;
  logic [15:0] r0_addr;
  logic [7:0]  r0_wdata;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [7:0]  r0_rdata;

  logic        r1_req;
  logic        r1_lock;
  logic        r1_we;
  logic [15:0] r1_addr;
  logic [7:0]  r1_wdata;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [7:0]  r1_rdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall0_cnt;
  logic [15:0] stall1_cnt;

  modport slave (
    input  r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output stall0_cnt, stall1_cnt
  );

  modport master (
    output r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  stall0_cnt, stall1_cnt
  );
`else
  modport slave (
    input  r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
`endif
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter with lockable ownership sharing one 8-bit/16-bit memory between CPU (port 0) and loader (port 1).
// Define MEM_ARB_STATS_EN to add the saturating per-requester stall counters.
module mem_bus_arbiter #(
  parameter int READ_LAT   = 1,
  parameter int RESET_PRIO = 0
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  localparam logic LP_RESET_PRIO = (RESET_PRIO != 0);

  owner_t              r_state;
  owner_t              w_stateNext;
  logic                r_prio;
  logic                w_prioNext;
  logic                w_gnt0;
  logic                w_gnt1;

  logic [15:0]         r_addrShadow;
  logic [7:0]          r_wdataShadow;
  logic [15:0]         w_memAddr;
  logic [7:0]          w_memWdata;
  logic                w_memWe;

  logic [READ_LAT-1:0] r_pipeValid;
  logic [READ_LAT-1:0] r_pipeTag;
  logic                w_issueRead;
  logic                w_retValid;
  logic                w_ret0;
  logic                w_ret1;
  logic [7:0]          r_rdata0;
  logic [7:0]          r_rdata1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FREE;
      r_prio  <= LP_RESET_PRIO;
    end else begin
      r_state <= w_stateNext;
      r_prio  <= w_prioNext;
    end
  end

  // Grants are gated by rst so nothing is accepted (or written) during a reset cycle.
  always_comb begin
    w_stateNext = r_state;
    w_prioNext  = r_prio;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    if (!rst) begin
      case (r_state)
        FREE: begin
          if (bus.r0_req && bus.r1_req) begin
            if (r_prio) w_gnt1 = 1'b1;
            else        w_gnt0 = 1'b1;
            w_prioNext = ~r_prio;
          end else begin
            w_gnt0 = bus.r0_req;
            w_gnt1 = bus.r1_req;
          end
          if (w_gnt0 && bus.r0_lock)      w_stateNext = OWN0;
          else if (w_gnt1 && bus.r1_lock) w_stateNext = OWN1;
        end
        OWN0: begin
          w_gnt0 = bus.r0_req;
          if (w_gnt0 && !bus.r0_lock) w_stateNext = FREE;
        end
        OWN1: begin
          w_gnt1 = bus.r1_req;
          if (w_gnt1 && !bus.r1_lock) w_stateNext = FREE;
        end
        default: w_stateNext = FREE;
      endcase
    end
  end

  always_comb begin
    w_memAddr  = r_addrShadow;
    w_memWdata = r_wdataShadow;
    w_memWe    = 1'b0;
    if (w_gnt0) begin
      w_memAddr  = bus.r0_addr;
      w_memWdata = bus.r0_wdata;
      w_memWe    = bus.r0_we;
    end else if (w_gnt1) begin
      w_memAddr  = bus.r1_addr;
      w_memWdata = bus.r1_wdata;
      w_memWe    = bus.r1_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addrShadow  <= 16'h0000;
      r_wdataShadow <= 8'h00;
    end else if (w_gnt0 || w_gnt1) begin
      r_addrShadow  <= w_memAddr;
      r_wdataShadow <= w_memWdata;
    end
  end

  assign bus.mem_addr  = w_memAddr;
  assign bus.mem_wdata = w_memWdata;
  assign bus.mem_we    = w_memWe;

  // Each granted read rides a READ_LAT-deep shift register tagged with the issuing port.
  assign w_issueRead = (w_gnt0 && !bus.r0_we) || (w_gnt1 && !bus.r1_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipeValid <= '0;
      r_pipeTag   <= '0;
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeTag[i]   <= r_pipeTag[i-1];
      end
      r_pipeValid[0] <= w_issueRead;
      r_pipeTag[0]   <= w_gnt1;
    end
  end

  assign w_retValid = r_pipeValid[READ_LAT-1] && !rst;
  assign w_ret0     = w_retValid && !r_pipeTag[READ_LAT-1];
  assign w_ret1     = w_retValid &&  r_pipeTag[READ_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata0 <= 8'h00;
      r_rdata1 <= 8'h00;
    end else begin
      if (w_ret0) r_rdata0 <= bus.mem_rdata;
      if (w_ret1) r_rdata1 <= bus.mem_rdata;
    end
  end

  assign bus.r0_gnt    = w_gnt0;
  assign bus.r1_gnt    = w_gnt1;
  assign bus.r0_rvalid = w_ret0;
  assign bus.r1_rvalid = w_ret1;
  assign bus.r0_rdata  = w_ret0 ? bus.mem_rdata : r_rdata0;
  assign bus.r1_rdata  = w_ret1 ? bus.mem_rdata : r_rdata1;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stall0Cnt;
  logic [15:0] r_stall1Cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall0Cnt <= 16'h0000;
      r_stall1Cnt <= 16'h0000;
    end else begin
      if (bus.r0_req && !w_gnt0 && (r_stall0Cnt != 16'hFFFF)) r_stall0Cnt <= r_stall0Cnt + 16'd1;
      if (bus.r1_req && !w_gnt1 && (r_stall1Cnt != 16'hFFFF)) r_stall1Cnt <= r_stall1Cnt + 16'd1;
    end
  end

  assign bus.stall0_cnt = r_stall0Cnt;
  assign bus.stall1_cnt = r_stall1Cnt;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives two arbiters (READ_LAT 1 and 3) with identical stimulus and checks both against a transaction-level model.
// Stall counters are checked too when MEM_ARB_STATS_EN is defined.
module tb_mem_bus_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    int         inst;
    int         due;
    int         who;
    logic [7:0] data;
  } ret_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        lock  [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [7:0]  wdata [2];

  mem_bus_arbiter_if busA ();
  mem_bus_arbiter_if busB ();

  mem_bus_arbiter #(.READ_LAT(LAT_A), .RESET_PRIO(0)) dutA (.clk(clk), .rst(rst), .bus(busA));
  mem_bus_arbiter #(.READ_LAT(LAT_B), .RESET_PRIO(0)) dutB (.clk(clk), .rst(rst), .bus(busB));

  assign busA.r0_req = req[0];  assign busA.r0_lock = lock[0];  assign busA.r0_we = we[0];
  assign busA.r0_addr = addr[0]; assign busA.r0_wdata = wdata[0];
  assign busA.r1_req = req[1];  assign busA.r1_lock = lock[1];  assign busA.r1_we = we[1];
  assign busA.r1_addr = addr[1]; assign busA.r1_wdata = wdata[1];
  assign busB.r0_req = req[0];  assign busB.r0_lock = lock[0];  assign busB.r0_we = we[0];
  assign busB.r0_addr = addr[0]; assign busB.r0_wdata = wdata[0];
  assign busB.r1_req = req[1];  assign busB.r1_lock = lock[1];  assign busB.r1_we = we[1];
  assign busB.r1_addr = addr[1]; assign busB.r1_wdata = wdata[1];

  function automatic logic [7:0] patt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA1;
  endfunction

  // Memory models: untouched locations read as patt(addr); data appears READ_LAT cycles after the address.
  bit          wrA  [65536];
  bit          wrB  [65536];
  logic [7:0]  memA [65536];
  logic [7:0]  memB [65536];
  logic [15:0] pipeA;
  logic [15:0] pipeB [3];

  always @(posedge clk) begin
    if (busA.mem_we) begin
      memA[busA.mem_addr] <= busA.mem_wdata;
      wrA[busA.mem_addr]  <= 1'b1;
    end
    pipeA <= busA.mem_addr;
  end

  always @(posedge clk) begin
    if (busB.mem_we) begin
      memB[busB.mem_addr] <= busB.mem_wdata;
      wrB[busB.mem_addr]  <= 1'b1;
    end
    pipeB[0] <= busB.mem_addr;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end

  assign busA.mem_rdata = wrA[pipeA]    ? memA[pipeA]    : patt(pipeA);
  assign busB.mem_rdata = wrB[pipeB[2]] ? memB[pipeB[2]] : patt(pipeB[2]);

  bit          refWr  [65536];
  logic [7:0]  refMem [65536];
  int          owner;
  int          turn;
  logic [15:0] shAddr;
  logic [7:0]  shData;
  ret_t        retQ [$];
  logic [7:0]  hold [2][2];
  int          stall [2];
  bit          expGnt [2];
  int          cycle;
  bit          checkEn;
  int          checkCount;
  int          passCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
    else
      passCount++;
  endtask

  function automatic logic [31:0] probe(input int k, input int sel);
    logic [31:0] v;
    v = '0;
    if (k == 0) begin
      case (sel)
        0: v[0]    = busA.r0_gnt;
        1: v[0]    = busA.r1_gnt;
        2: v[0]    = busA.r0_rvalid;
        3: v[0]    = busA.r1_rvalid;
        4: v[7:0]  = busA.r0_rdata;
        5: v[7:0]  = busA.r1_rdata;
        6: v[0]    = busA.mem_we;
        7: v[15:0] = busA.mem_addr;
        8: v[7:0]  = busA.mem_wdata;
`ifdef MEM_ARB_STATS_EN
        9: v[15:0]  = busA.stall0_cnt;
        10: v[15:0] = busA.stall1_cnt;
`endif
        default: v = '0;
      endcase
    end else begin
      case (sel)
        0: v[0]    = busB.r0_gnt;
        1: v[0]    = busB.r1_gnt;
        2: v[0]    = busB.r0_rvalid;
        3: v[0]    = busB.r1_rvalid;
        4: v[7:0]  = busB.r0_rdata;
        5: v[7:0]  = busB.r1_rdata;
        6: v[0]    = busB.mem_we;
        7: v[15:0] = busB.mem_addr;
        8: v[7:0]  = busB.mem_wdata;
`ifdef MEM_ARB_STATS_EN
        9: v[15:0]  = busB.stall0_cnt;
        10: v[15:0] = busB.stall1_cnt;
`endif
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // One clock: predict this cycle's outputs from the arbitration rules, compare at negedge, then advance the model.
  task automatic runCycle();
    int          g;
    bit          expV [2][2];
    ret_t        keep [$];
    logic        expWe;
    logic [15:0] expAddr;
    logic [7:0]  expData;
    logic [7:0]  rd;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (owner < 0) begin
        if (req[0] && req[1]) begin
          g    = turn;
          turn = 1 - turn;
        end else if (req[0]) g = 0;
        else if (req[1])     g = 1;
        if (g >= 0 && lock[g]) owner = g;
      end else if (req[owner]) begin
        g = owner;
        if (!lock[g]) owner = -1;
      end
    end
    expGnt[0] = (g == 0);
    expGnt[1] = (g == 1);
    expWe   = (g >= 0) ? we[g]    : 1'b0;
    expAddr = (g >= 0) ? addr[g]  : shAddr;
    expData = (g >= 0) ? wdata[g] : shData;

    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) expV[k][p] = 1'b0;
    foreach (retQ[i]) begin
      if (retQ[i].due == cycle) begin
        if (!rst) begin
          expV[retQ[i].inst][retQ[i].who] = 1'b1;
          hold[retQ[i].inst][retQ[i].who] = retQ[i].data;
        end
      end else keep.push_back(retQ[i]);
    end
    retQ = keep;

    if (checkEn) begin
      for (int k = 0; k < 2; k++) begin
        string n;
        n = (k == 0) ? "A" : "B";
        checkOutput({n, ".gnt0"},    probe(k, 0), 32'(expGnt[0]));
        checkOutput({n, ".gnt1"},    probe(k, 1), 32'(expGnt[1]));
        checkOutput({n, ".rvalid0"}, probe(k, 2), 32'(expV[k][0]));
        checkOutput({n, ".rvalid1"}, probe(k, 3), 32'(expV[k][1]));
        checkOutput({n, ".rdata0"},  probe(k, 4), 32'(hold[k][0]));
        checkOutput({n, ".rdata1"},  probe(k, 5), 32'(hold[k][1]));
        checkOutput({n, ".mem_we"},  probe(k, 6), 32'(expWe));
        checkOutput({n, ".mem_addr"},  probe(k, 7), 32'(expAddr));
        checkOutput({n, ".mem_wdata"}, probe(k, 8), 32'(expData));
`ifdef MEM_ARB_STATS_EN
        checkOutput({n, ".stall0"}, probe(k, 9),  32'(stall[0]));
        checkOutput({n, ".stall1"}, probe(k, 10), 32'(stall[1]));
`endif
      end
    end

    if (g >= 0) begin
      if (we[g]) begin
        refMem[addr[g]] = wdata[g];
        refWr[addr[g]]  = 1'b1;
      end else begin
        rd = refWr[addr[g]] ? refMem[addr[g]] : patt(addr[g]);
        retQ.push_back('{inst: 0, due: cycle + LAT_A, who: g, data: rd});
        retQ.push_back('{inst: 1, due: cycle + LAT_B, who: g, data: rd});
      end
      shAddr = addr[g];
      shData = wdata[g];
    end
    for (int p = 0; p < 2; p++)
      if (!rst && req[p] && !expGnt[p] && stall[p] < 65535) stall[p]++;

    if (rst) begin
      owner  = -1;
      turn   = 0;
      shAddr = 16'h0000;
      shData = 8'h00;
      retQ.delete();
      for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) hold[k][p] = 8'h00;
      for (int p = 0; p < 2; p++) stall[p] = 0;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic rq0, input logic lk0, input logic we0, input logic [15:0] a0,
                               input logic [7:0] d0, input logic rq1, input logic lk1, input logic we1,
                               input logic [15:0] a1, input logic [7:0] d1);
    req[0] = rq0; lock[0] = lk0; we[0] = we0; addr[0] = a0; wdata[0] = d0;
    req[1] = rq1; lock[1] = lk1; we[1] = we1; addr[1] = a1; wdata[1] = d1;
    runCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    cycle      = 0;
    owner      = -1;
    turn       = 0;
    checkEn    = 1'b0;
    rst        = 1'b1;
    idle(1);
    checkEn = 1'b1;
    idle(1);
    rst = 1'b0;

    // Single CPU read of 0x0004 (pattern value A5).
    applyStimulus(1, 0, 0, 16'h0004, 8'h00, 0, 0, 0, 16'h0, 8'h0);
    idle(4);

    // Continuous contended reads from reset: strict alternation, pipelined returns.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 16'h0010, 8'h00, 1, 0, 0, 16'h0020, 8'h00);
    idle(4);

    // Locked r1 write burst while r0 keeps requesting.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, 16'h0010, 8'h00, 1, (i < 3), 1, 16'(i), 8'(8'h10 + i));
    applyStimulus(1, 0, 0, 16'h0010, 8'h00, 0, 0, 0, 16'h0, 8'h0);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("memA.burst", 32'(wrA[i] ? memA[i] : 8'h00), 32'(8'h10 + i));
      checkOutput("memB.burst", 32'(wrB[i] ? memB[i] : 8'h00), 32'(8'h10 + i));
    end

    // Reset one cycle after a granted read, then a contended access.
    applyStimulus(1, 0, 0, 16'h0030, 8'h00, 0, 0, 0, 16'h0, 8'h0);
    doReset();
    idle(4);
    applyStimulus(1, 0, 0, 16'h0040, 8'h00, 1, 0, 0, 16'h0050, 8'h00);
    idle(4);

    // Random traffic; a requester holds its transaction until it is granted.
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && !expGnt[p])) begin
          req[p]   = ($urandom_range(0, 99) < 60);
          lock[p]  = ($urandom_range(0, 3) == 0);
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = we[p] ? {1'b1, 15'($urandom)} : {1'b0, 15'($urandom)};
          wdata[p] = 8'($urandom);
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      runCycle();
    end
    rst = 1'b0;
    idle(6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
